// File: rtl/mac_rx_frame_parser_if.sv
// Buffer read port toward the GbE RX MAC and payload byte stream toward the command decoder.
// The parser is the master of both: it drives addresses and payload, the far side returns data/ready.
interface mac_rx_frame_parser_if;
  logic        Rd_en;
  logic [13:0] Rd_Addr;
  logic [7:0]  Rd_data;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_last;
  logic        cmd_ready;

  modport master (
    output Rd_en, Rd_Addr, cmd_data, cmd_valid, cmd_last,
    input  Rd_data, cmd_ready
  );

  modport slave (
    input  Rd_en, Rd_Addr, cmd_data, cmd_valid, cmd_last,
    output Rd_data, cmd_ready
  );
endinterface

// File: rtl/mac_rx_frame_parser.sv
// Reads each new frame out of the MAC buffer, filters on destination/EtherType/length,
// and streams accepted payload bytes through a 2-entry FIFO; rejected or missed frames are counted.
//
// state   | meaning
// IDLE    | waiting for a Frm_valid rising edge
// HDR     | issuing header reads 0..15, capturing each byte one cycle later
// CHECK   | one-cycle accept/reject decision on the captured header
// PAYLOAD | reading payload under FIFO credit, streaming on cmd_*
// DONE    | frm_done pulse; parser already free for the next frame
// DROP    | frm_drop pulse and drop_cnt increment
module mac_rx_frame_parser #(
  parameter logic [47:0] MY_MAC   = 48'h0002_0304_0506,
  parameter logic [15:0] ETH_TYPE = 16'h0800,
  parameter int unsigned MAX_LEN  = 1500
) (
  input  logic                  Rd_Clk,
  input  logic                  reset,
  input  logic                  Frm_valid,
  mac_rx_frame_parser_if.master bus,
  output logic [47:0]           src_mac,
  output logic                  frm_done,
  output logic                  frm_drop,
  output logic [15:0]           drop_cnt,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CHECK,
    S_PAYLOAD,
    S_DONE,
    S_DROP
  } state_t;

  state_t       state_q, state_d;
  logic         sync1_q, sync2_q, hist_q;
  logic         frm_edge;
  logic [4:0]   hdr_idx_q;
  logic [127:0] hdr_q;
  logic [15:0]  pay_idx_q;
  logic         rd_vld_q, rd_last_q;
  logic [7:0]   fifo_data_q [2];
  logic [1:0]   fifo_last_q;
  logic         fifo_wr_q, fifo_rd_q;
  logic [1:0]   fifo_cnt_q;
  logic [13:0]  rd_addr_q, rd_addr_d;
  logic         rd_en, push, pop, frame_ok, can_start, miss;
  logic [2:0]   occ;
  logic [1:0]   drop_inc;
  logic [16:0]  drop_sum;
  logic [47:0]  dst_mac;
  logic [15:0]  eth_type, pay_len;

  assign dst_mac  = hdr_q[127:80];
  assign eth_type = hdr_q[31:16];
  assign pay_len  = hdr_q[15:0];
  assign frame_ok = ((dst_mac == MY_MAC) || (dst_mac == {48{1'b1}})) &&
                    (eth_type == ETH_TYPE) && (pay_len != 16'd0) &&
                    (32'(pay_len) <= MAX_LEN);

  assign frm_edge = sync2_q & ~hist_q;

  // DONE counts as free so busy drops on the same edge that raises frm_done.
  assign can_start = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy      = ~can_start;
  assign miss      = frm_edge & ~can_start;
  assign frm_done  = (state_q == S_DONE);
  assign frm_drop  = (state_q == S_DROP);

  assign bus.cmd_valid = (fifo_cnt_q != 2'd0);
  assign bus.cmd_data  = fifo_data_q[fifo_rd_q];
  assign bus.cmd_last  = bus.cmd_valid & fifo_last_q[fifo_rd_q];
  assign pop           = bus.cmd_valid & bus.cmd_ready;
  assign push          = (state_q == S_PAYLOAD) & rd_vld_q;

  // Credit counts the slot freed by this cycle's pop, which keeps 1 byte/cycle with a 2-deep FIFO.
  assign occ = 3'(fifo_cnt_q) + 3'(rd_vld_q) - 3'(pop);

  assign bus.Rd_en   = rd_en;
  assign bus.Rd_Addr = rd_en ? rd_addr_d : rd_addr_q;

  assign drop_inc = 2'(state_q == S_DROP) + 2'(miss);
  assign drop_sum = 17'(drop_cnt) + 17'(drop_inc);

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_q)
      S_IDLE: begin
        if (frm_edge) state_d = S_HDR;
      end
      S_HDR: begin
        if (hdr_idx_q < 5'd16) begin
          rd_en     = 1'b1;
          rd_addr_d = 14'(hdr_idx_q);
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = frame_ok ? S_PAYLOAD : S_DROP;
      end
      S_PAYLOAD: begin
        if ((pay_idx_q < pay_len) && (occ < 3'd2)) begin
          rd_en     = 1'b1;
          rd_addr_d = 14'(pay_idx_q + 16'd16);
        end
        if (pop && bus.cmd_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = frm_edge ? S_HDR : S_IDLE;
      end
      S_DROP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Rd_Clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      // All-ones history hides a frame that is already pending when reset releases.
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      hist_q         <= 1'b1;
      hdr_idx_q      <= '0;
      hdr_q          <= '0;
      pay_idx_q      <= '0;
      rd_vld_q       <= 1'b0;
      rd_last_q      <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      fifo_wr_q      <= 1'b0;
      fifo_rd_q      <= 1'b0;
      fifo_cnt_q     <= '0;
      rd_addr_q      <= '0;
      src_mac        <= '0;
      drop_cnt       <= '0;
    end else begin
      sync1_q   <= Frm_valid;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      state_q   <= state_d;
      rd_vld_q  <= rd_en;
      rd_last_q <= rd_en && (state_q == S_PAYLOAD) && (pay_idx_q == pay_len - 16'd1);

      if (rd_en) rd_addr_q <= rd_addr_d;

      if (state_q == S_HDR) hdr_idx_q <= hdr_idx_q + 5'd1;
      else                  hdr_idx_q <= '0;

      if ((state_q == S_HDR) && rd_vld_q) hdr_q <= {hdr_q[119:0], bus.Rd_data};

      if (state_q == S_PAYLOAD) begin
        if (rd_en) pay_idx_q <= pay_idx_q + 16'd1;
      end else begin
        pay_idx_q <= '0;
      end

      if ((state_q == S_CHECK) && frame_ok) src_mac <= hdr_q[79:32];

      if (push) begin
        fifo_data_q[fifo_wr_q] <= bus.Rd_data;
        fifo_last_q[fifo_wr_q] <= rd_last_q;
        fifo_wr_q              <= ~fifo_wr_q;
      end
      if (pop) fifo_rd_q <= ~fifo_rd_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);

      if (drop_sum[16]) drop_cnt <= 16'hFFFF;
      else              drop_cnt <= drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_mac_rx_frame_parser.sv
// Directed bench for mac_rx_frame_parser: a registered buffer model feeds frames,
// a negedge monitor records reads, handshakes and pulses for hand-computed expectations.
module tb_mac_rx_frame_parser;

  localparam logic [47:0] MY_MAC = 48'h0002_0304_0506;

  logic        Rd_Clk = 1'b0;
  logic        reset;
  logic        Frm_valid;
  logic [47:0] src_mac;
  logic        frm_done, frm_drop, busy;
  logic [15:0] drop_cnt;

  mac_rx_frame_parser_if bus ();

  mac_rx_frame_parser #(
    .MY_MAC  (MY_MAC),
    .ETH_TYPE(16'h0800),
    .MAX_LEN (1500)
  ) dut (
    .Rd_Clk   (Rd_Clk),
    .reset    (reset),
    .Frm_valid(Frm_valid),
    .bus      (bus),
    .src_mac  (src_mac),
    .frm_done (frm_done),
    .frm_drop (frm_drop),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 Rd_Clk = ~Rd_Clk;

  logic [7:0] buf_mem [0:2047];
  always @(posedge Rd_Clk) if (bus.Rd_en) bus.Rd_data <= buf_mem[bus.Rd_Addr[10:0]];

  int cyc = 0;
  always @(posedge Rd_Clk) cyc <= cyc + 1;

  int n_chk, n_fail;
  int rdy_mode;
  int first_rden, first_addr, first_pay, first_hs, last_hs, done_cyc, drop_cyc, rise_cyc;
  int done_cnt, drop_pulses, vcnt, max_addr, busy_seen, viol, stall, out_cnt;
  logic busy_at_done;
  logic [7:0] rx_data [$];
  logic       rx_last [$];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    first_rden = -1; first_addr = -1; first_pay = -1; first_hs = -1; last_hs = -1;
    done_cyc = -1; drop_cyc = -1; done_cnt = 0; drop_pulses = 0; vcnt = 0;
    max_addr = -1; busy_seen = 0; viol = 0; stall = 0; out_cnt = 0; busy_at_done = 1'bx;
    rx_data.delete();
    rx_last.delete();
  endtask

  task automatic mon_loop();
    logic pop_s, iss_s;
    forever begin
      @(negedge Rd_Clk);
      pop_s = bus.cmd_valid && bus.cmd_ready;
      iss_s = bus.Rd_en && (bus.Rd_Addr >= 14'd16);
      if (bus.Rd_en) begin
        if (first_rden < 0) begin
          first_rden = cyc;
          first_addr = int'(bus.Rd_Addr);
        end
        if (int'(bus.Rd_Addr) > max_addr) max_addr = int'(bus.Rd_Addr);
      end
      if (iss_s && first_pay < 0) first_pay = cyc;
      if (iss_s && (out_cnt - int'(pop_s)) >= 2) viol++;
      if (out_cnt >= 2 && !pop_s) stall++;
      out_cnt = out_cnt + int'(iss_s) - int'(pop_s);
      if (pop_s) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        rx_data.push_back(bus.cmd_data);
        rx_last.push_back(bus.cmd_last);
      end
      if (bus.cmd_valid) vcnt++;
      if (busy) busy_seen++;
      if (frm_done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (frm_drop) begin
        drop_pulses++;
        drop_cyc = cyc;
      end
    end
  endtask

  task automatic rdy_loop();
    int ph;
    ph = 0;
    forever begin
      @(posedge Rd_Clk);
      #1;
      if (rdy_mode == 1) begin
        bus.cmd_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
        ph++;
      end else begin
        bus.cmd_ready = 1'b1;
        ph = 0;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Rd_Clk);
      #1;
    end
  endtask

  task automatic load_frame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] et, input logic [15:0] len, input logic [7:0] seed);
    for (int i = 0; i < 6; i++) begin
      buf_mem[i]     = dst[47-8*i -: 8];
      buf_mem[6 + i] = src[47-8*i -: 8];
    end
    buf_mem[12] = et[15:8];
    buf_mem[13] = et[7:0];
    buf_mem[14] = len[15:8];
    buf_mem[15] = len[7:0];
    for (int i = 0; i < 2032; i++) buf_mem[16 + i] = 8'(int'(seed) + i);
  endtask

  task automatic pulse_frm();
    tick(1);
    Frm_valid = 1'b1;
    rise_cyc  = cyc;
    tick(4);
    Frm_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int budget);
    int n;
    n = 0;
    pulse_frm();
    while (!(busy_seen > 0 && !busy) && n < budget) begin
      tick(1);
      n++;
    end
    chk_eq({tag, " finished"}, 64'(busy_seen > 0 && !busy), 64'd1);
    tick(3);
  endtask

  task automatic wait_first_pay(input string tag, input int budget);
    int n;
    n = 0;
    while (first_pay < 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk_eq({tag, " payload started"}, 64'(first_pay >= 0), 64'd1);
  endtask

  task automatic chk_payload(input string tag, input int len, input logic [7:0] seed);
    int errs;
    errs = 0;
    chk_eq({tag, " byte count"}, 64'(rx_data.size()), 64'(len));
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== 8'(int'(seed) + i)) errs++;
      if (rx_last[i] !== (i == len - 1)) errs++;
    end
    chk_eq({tag, " bytes/last"}, 64'(errs), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    n_chk = 0; n_fail = 0;
    reset = 1'b1; Frm_valid = 1'b1; bus.cmd_ready = 1'b1; rdy_mode = 0;
    clear_mon();
    fork
      mon_loop();
      rdy_loop();
    join_none

    // reset values
    tick(3);
    chk_eq("rst Rd_en",     64'(bus.Rd_en),     64'd0);
    chk_eq("rst Rd_Addr",   64'(bus.Rd_Addr),   64'd0);
    chk_eq("rst cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk_eq("rst cmd_last",  64'(bus.cmd_last),  64'd0);
    chk_eq("rst cmd_data",  64'(bus.cmd_data),  64'd0);
    chk_eq("rst src_mac",   64'(src_mac),       64'd0);
    chk_eq("rst drop_cnt",  64'(drop_cnt),      64'd0);
    chk_eq("rst pulses",    64'({busy, frm_done, frm_drop}), 64'd0);

    // frame already pending at reset release must be ignored
    reset = 1'b0;
    clear_mon();
    tick(10);
    chk_eq("pending ignored busy", 64'(busy_seen), 64'd0);
    chk_eq("pending ignored drop", 64'(drop_cnt), 64'd0);
    Frm_valid = 1'b0;
    tick(3);

    // broadcast, L=4, payload 11 22 33 44
    load_frame(48'hFFFF_FFFF_FFFF, 48'h0A0B_0C0D_0E0F, 16'h0800, 16'd4, 8'h00);
    buf_mem[16] = 8'h11; buf_mem[17] = 8'h22; buf_mem[18] = 8'h33; buf_mem[19] = 8'h44;
    clear_mon();
    run_frame("t1", 200);
    chk_eq("t1 count",   64'(rx_data.size()), 64'd4);
    if (rx_data.size() == 4) begin
      chk_eq("t1 data", 64'({rx_data[0], rx_data[1], rx_data[2], rx_data[3]}), 64'h1122_3344);
      chk_eq("t1 last", 64'({rx_last[3], rx_last[2], rx_last[1], rx_last[0]}), 64'b1000);
    end
    chk_eq("t1 frm_done count",   64'(done_cnt),              64'd1);
    chk_eq("t1 src_mac",          64'(src_mac),               64'h0A0B_0C0D_0E0F);
    chk_eq("t1 rise to Rd_en",    64'(first_rden - rise_cyc), 64'd3);
    chk_eq("t1 first addr",       64'(first_addr),            64'd0);
    chk_eq("t1 hdr to payload",   64'(first_pay - first_rden), 64'd18);
    chk_eq("t1 issue to 1st hs",  64'(first_hs - first_pay),  64'd2);
    chk_eq("t1 issue to last hs", 64'(last_hs - first_pay),   64'd5);
    chk_eq("t1 back-to-back",     64'(last_hs - first_hs),    64'd3);
    chk_eq("t1 done after hs",    64'(done_cyc - last_hs),    64'd1);
    chk_eq("t1 busy at done",     64'(busy_at_done),          64'd0);
    chk_eq("t1 drop_cnt",         64'(drop_cnt),              64'd0);

    // wrong destination
    load_frame(48'hAAAA_AAAA_AAAA, 48'h0102_0304_0506, 16'h0800, 16'd4, 8'h00);
    clear_mon();
    run_frame("t2", 200);
    chk_eq("t2 drop pulses",   64'(drop_pulses),           64'd1);
    chk_eq("t2 drop_cnt",      64'(drop_cnt),              64'd1);
    chk_eq("t2 cmd_valid",     64'(vcnt),                  64'd0);
    chk_eq("t2 max addr",      64'(max_addr),              64'd15);
    chk_eq("t2 drop timing",   64'(drop_cyc - first_rden), 64'd18);
    chk_eq("t2 src_mac kept",  64'(src_mac),               64'h0A0B_0C0D_0E0F);

    // length bounds
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    load_frame(MY_MAC, 48'h1234_5678_9ABC, 16'h0800, 16'd0, 8'h00);
    clear_mon();
    run_frame("t3a", 200);
    chk_eq("t3 L=0 dropped", 64'(drop_pulses), 64'd1);
    load_frame(MY_MAC, 48'h1234_5678_9ABC, 16'h0800, 16'd1501, 8'h00);
    clear_mon();
    run_frame("t3b", 200);
    chk_eq("t3 L=1501 dropped", 64'(drop_pulses), 64'd1);
    chk_eq("t3 drop_cnt",       64'(drop_cnt),    64'd2);
    load_frame(MY_MAC, 48'h1234_5678_9ABC, 16'h0800, 16'd1500, 8'h00);
    clear_mon();
    run_frame("t3c", 2500);
    chk_payload("t3 L=1500", 1500, 8'h00);
    chk_eq("t3 final Rd_Addr", 64'(bus.Rd_Addr), 64'd1515);
    chk_eq("t3 max addr",      64'(max_addr),    64'd1515);
    chk_eq("t3 frm_done",      64'(done_cnt),    64'd1);
    chk_eq("t3 src_mac",       64'(src_mac),     64'h1234_5678_9ABC);
    chk_eq("t3 drop_cnt kept", 64'(drop_cnt),    64'd2);

    // backpressure 1,0,0,1
    load_frame(MY_MAC, 48'h0000_0000_0001, 16'h0800, 16'd8, 8'hA0);
    clear_mon();
    rdy_mode = 1;
    run_frame("t4", 300);
    rdy_mode = 0;
    chk_payload("t4 L=8", 8, 8'hA0);
    chk_eq("t4 read while full", 64'(viol),      64'd0);
    chk_eq("t4 fifo filled",     64'(stall > 0), 64'd1);
    chk_eq("t4 frm_done",        64'(done_cnt),  64'd1);

    // second frame edge during payload is counted, not queued
    load_frame(MY_MAC, 48'h0000_0000_0002, 16'h0800, 16'd20, 8'h40);
    base = int'(drop_cnt);
    clear_mon();
    fork
      run_frame("t5", 300);
      begin
        wait_first_pay("t5", 200);
        pulse_frm();
      end
    join
    chk_payload("t5 L=20", 20, 8'h40);
    chk_eq("t5 frm_done",    64'(done_cnt),              64'd1);
    chk_eq("t5 no drop",     64'(drop_pulses),           64'd0);
    chk_eq("t5 miss counted", 64'(int'(drop_cnt) - base), 64'd1);
    chk_eq("t5 idle after",  64'(busy),                  64'd0);

    // reset during payload, then a clean frame
    load_frame(MY_MAC, 48'h0000_0000_0003, 16'h0800, 16'd20, 8'h60);
    clear_mon();
    pulse_frm();
    wait_first_pay("t6", 200);
    tick(5);
    reset = 1'b1;
    @(posedge Rd_Clk);
    @(negedge Rd_Clk);
    chk_eq("t6 rst ctrl",     64'({bus.Rd_en, bus.cmd_valid, bus.cmd_last, busy, frm_done, frm_drop}), 64'd0);
    chk_eq("t6 rst Rd_Addr",  64'(bus.Rd_Addr),  64'd0);
    chk_eq("t6 rst cmd_data", 64'(bus.cmd_data), 64'd0);
    chk_eq("t6 rst src_mac",  64'(src_mac),      64'd0);
    chk_eq("t6 rst drop_cnt", 64'(drop_cnt),     64'd0);
    tick(1);
    reset = 1'b0;
    tick(3);
    load_frame(MY_MAC, 48'h1122_3344_5566, 16'h0800, 16'd3, 8'h80);
    clear_mon();
    run_frame("t6b", 200);
    chk_payload("t6 after reset", 3, 8'h80);
    chk_eq("t6 first addr", 64'(first_addr), 64'd0);
    chk_eq("t6 frm_done",   64'(done_cnt),   64'd1);
    chk_eq("t6 src_mac",    64'(src_mac),    64'h1122_3344_5566);
    chk_eq("t6 drop_cnt",   64'(drop_cnt),   64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
